// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory-port arbiter of the multicycle MIPS datapath.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_LOAD = 1'b1;

   localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention the requester that did not win last time is chosen.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      valid  = |req;
      winner = REQ_CORE;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[1]) begin
         winner = REQ_LOAD;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and transaction sequencer for the single shared memory port; every output is registered.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    ack,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          owner,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state;
   state_t        state_nxt;
   logic          last_grant;
   logic [CW-1:0] cnt;
   logic          pick_valid;
   logic          pick_winner;
   logic          timeout_hit;
   logic [1:0]    ack_owner;

   rr_pick2 u_pick (
      .req    (req),
      .last   (last_grant),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // The counter holds the number of ACCESS cycles already spent without mem_ready.
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   assign ack_owner   = owner ? 2'b10 : 2'b01;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ACCESS;
         ACCESS:  if (mem_ready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack        <= '0;
         err        <= 1'b0;
         rdata      <= '0;
         busy       <= 1'b0;
         owner      <= REQ_CORE;
         last_grant <= REQ_LOAD;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cnt        <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         ack   <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner      <= pick_winner;
                  last_grant <= pick_winner;
                  mem_req    <= 1'b1;
                  mem_we     <= we[pick_winner];
                  mem_addr   <= pick_winner ? addr1 : addr0;
                  mem_wdata  <= pick_winner ? wdata1 : wdata0;
                  cnt        <= '0;
               end
            end
            ACCESS: begin
               // A response arriving in the last allowed cycle beats the timeout.
               if (mem_ready) begin
                  rdata   <= mem_rdata;
                  err     <= 1'b0;
                  ack     <= ack_owner;
                  mem_req <= 1'b0;
               end else if (timeout_hit) begin
                  rdata   <= '0;
                  err     <= 1'b1;
                  ack     <= ack_owner;
                  mem_req <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (default and short timeout) checked every cycle against a transaction model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic [1:0]  req       [2];
   logic [1:0]  we        [2];
   logic [31:0] addr0     [2];
   logic [31:0] addr1     [2];
   logic [31:0] wdata0    [2];
   logic [31:0] wdata1    [2];
   logic        mem_ready [2];
   logic [31:0] mem_rdata [2];

   logic [1:0]  ack_o       [2];
   logic        err_o       [2];
   logic [31:0] rdata_o     [2];
   logic        busy_o      [2];
   logic        owner_o     [2];
   logic        mem_req_o   [2];
   logic        mem_we_o    [2];
   logic [31:0] mem_addr_o  [2];
   logic [31:0] mem_wdata_o [2];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) u_dut0 (
      .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]),
      .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
      .ack(ack_o[0]), .err(err_o[0]), .rdata(rdata_o[0]), .busy(busy_o[0]), .owner(owner_o[0]),
      .mem_req(mem_req_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_wdata(mem_wdata_o[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0])
   );

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut1 (
      .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]),
      .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
      .ack(ack_o[1]), .err(err_o[1]), .rdata(rdata_o[1]), .busy(busy_o[1]), .owner(owner_o[1]),
      .mem_req(mem_req_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_wdata(mem_wdata_o[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level model: a granted transfer ends on the first ready cycle or on its to-th waiting cycle.
   typedef struct {
      bit          active;
      bit          resp;
      int          waited;
      bit          own;
      bit          last;
      logic [1:0]  ack;
      logic        err;
      logic [31:0] rdata;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        busy;
   } model_t;

   model_t mdl [2];

   function automatic model_t next_model(input model_t c, input logic r, input logic [1:0] rq,
                                         input logic [1:0] w, input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] d0, input logic [31:0] d1, input logic rdy,
                                         input logic [31:0] rd, input int to);
      model_t n;
      bit g;
      bit done;
      n    = c;
      done = 1'b0;
      if (r) begin
         n = '{default: 0};
         n.last = 1'b1;
         return n;
      end
      n.ack = 2'b00;
      if (c.resp) begin
         n.resp = 1'b0;
      end else if (c.active) begin
         if (rdy) begin
            done = 1'b1; n.err = 1'b0; n.rdata = rd;
         end else if (to != 0 && c.waited + 1 == to) begin
            done = 1'b1; n.err = 1'b1; n.rdata = 32'h0;
         end else begin
            n.waited = c.waited + 1;
         end
         if (done) begin
            n.active = 1'b0; n.resp = 1'b1; n.mem_req = 1'b0;
            n.ack = c.own ? 2'b10 : 2'b01;
         end
      end else if (rq != 2'b00) begin
         g = (rq == 2'b11) ? !c.last : rq[1];
         n.own = g; n.last = g; n.active = 1'b1; n.waited = 0; n.mem_req = 1'b1;
         n.mem_we    = w[g];
         n.mem_addr  = g ? a1 : a0;
         n.mem_wdata = g ? d1 : d0;
      end
      n.busy = n.active || n.resp;
      return n;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mdl[k] <= next_model(mdl[k], rst[k], req[k], we[k], addr0[k], addr1[k], wdata0[k], wdata1[k],
                              mem_ready[k], mem_rdata[k], (k == 0) ? 255 : 4);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d.ack", k), 64'(ack_o[k]), 64'(mdl[k].ack));
            check($sformatf("dut%0d.busy", k), 64'(busy_o[k]), 64'(mdl[k].busy));
            check($sformatf("dut%0d.owner", k), 64'(owner_o[k]), 64'(mdl[k].own));
            check($sformatf("dut%0d.mem_req", k), 64'(mem_req_o[k]), 64'(mdl[k].mem_req));
            if (mdl[k].mem_req) begin
               check($sformatf("dut%0d.mem_we", k), 64'(mem_we_o[k]), 64'(mdl[k].mem_we));
               check($sformatf("dut%0d.mem_addr", k), 64'(mem_addr_o[k]), 64'(mdl[k].mem_addr));
               check($sformatf("dut%0d.mem_wdata", k), 64'(mem_wdata_o[k]), 64'(mdl[k].mem_wdata));
            end
            if (mdl[k].ack != 2'b00) begin
               check($sformatf("dut%0d.err", k), 64'(err_o[k]), 64'(mdl[k].err));
               check($sformatf("dut%0d.rdata", k), 64'(rdata_o[k]), 64'(mdl[k].rdata));
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] got [$];

      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; req[k] = 2'b00; we[k] = 2'b00;
         addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
         mem_ready[k] = 1'b0; mem_rdata[k] = '0;
      end
      tick(); tick();
      chk_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset%0d.ack", k), 64'(ack_o[k]), 64'h0);
         check($sformatf("reset%0d.busy", k), 64'(busy_o[k]), 64'h0);
         check($sformatf("reset%0d.mem_req", k), 64'(mem_req_o[k]), 64'h0);
         check($sformatf("reset%0d.owner", k), 64'(owner_o[k]), 64'h0);
         check($sformatf("reset%0d.rdata", k), 64'(rdata_o[k]), 64'h0);
         check($sformatf("reset%0d.mem_addr", k), 64'(mem_addr_o[k]), 64'h0);
         rst[k] = 1'b0;
      end

      // Single core read, memory answers in the first access cycle.
      req[0] = 2'b01; addr0[0] = 32'h40;
      tick();
      check("rd1.mem_req", 64'(mem_req_o[0]), 64'h1);
      check("rd1.mem_addr", 64'(mem_addr_o[0]), 64'h40);
      mem_ready[0] = 1'b1; mem_rdata[0] = 32'h8C02_0004;
      tick();
      check("rd1.ack", 64'(ack_o[0]), 64'h1);
      check("rd1.rdata", 64'(rdata_o[0]), 64'h8C02_0004);
      check("rd1.err", 64'(err_o[0]), 64'h0);
      mem_ready[0] = 1'b0; req[0] = 2'b00;
      tick();
      check("rd1.idle", 64'(busy_o[0]), 64'h0);

      // Continuous contention from reset: grants must alternate core, loader, core, loader.
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0; req[0] = 2'b11; addr0[0] = 32'h200; addr1[0] = 32'h300;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_req_o[0]) got.push_back(mem_addr_o[0]);
         mem_ready[0] = mem_req_o[0];
         mem_rdata[0] = 32'h1000 + 32'(i);
      end
      req[0] = 2'b00; mem_ready[0] = 1'b0;
      check("rr.count", 64'(got.size()), 64'd4);
      if (got.size() == 4) begin
         check("rr.grant0", 64'(got[0]), 64'h200);
         check("rr.grant1", 64'(got[1]), 64'h300);
         check("rr.grant2", 64'(got[2]), 64'h200);
         check("rr.grant3", 64'(got[3]), 64'h300);
      end
      tick();

      // Loader write with a five-cycle memory latency.
      req[0] = 2'b10; we[0] = 2'b10; addr1[0] = 32'h100; wdata1[0] = 32'hDEAD_BEEF;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("wr.c%0d.mem_req", i), 64'(mem_req_o[0]), 64'h1);
         check($sformatf("wr.c%0d.mem_we", i), 64'(mem_we_o[0]), 64'h1);
         check($sformatf("wr.c%0d.mem_addr", i), 64'(mem_addr_o[0]), 64'h100);
         check($sformatf("wr.c%0d.mem_wdata", i), 64'(mem_wdata_o[0]), 64'hDEAD_BEEF);
         check($sformatf("wr.c%0d.ack", i), 64'(ack_o[0]), 64'h0);
         if (i == 5) begin
            mem_ready[0] = 1'b1; mem_rdata[0] = 32'h0BAD_F00D;
         end
      end
      tick();
      check("wr.ack", 64'(ack_o[0]), 64'h2);
      mem_ready[0] = 1'b0; req[0] = 2'b00; we[0] = 2'b00;
      tick();

      // Reset in the second access cycle abandons the transfer; the next contention goes to the core.
      req[0] = 2'b01; addr0[0] = 32'h500; addr1[0] = 32'h600;
      tick();
      tick();
      check("rst.busy_before", 64'(busy_o[0]), 64'h1);
      rst[0] = 1'b1;
      tick();
      check("rst.mem_req", 64'(mem_req_o[0]), 64'h0);
      check("rst.busy", 64'(busy_o[0]), 64'h0);
      check("rst.ack", 64'(ack_o[0]), 64'h0);
      rst[0] = 1'b0; req[0] = 2'b11;
      tick();
      check("rst.owner", 64'(owner_o[0]), 64'h0);
      check("rst.mem_addr", 64'(mem_addr_o[0]), 64'h500);
      mem_ready[0] = 1'b1; mem_rdata[0] = 32'h55;
      req[0] = 2'b00;
      tick();
      check("rst.ack_after", 64'(ack_o[0]), 64'h1);
      mem_ready[0] = 1'b0;
      tick();

      // Core drops req mid-transfer; stray mem_ready pulses in RESP/IDLE must not ack.
      req[0] = 2'b01; addr0[0] = 32'h700;
      tick();
      req[0] = 2'b00;
      tick();
      tick();
      mem_ready[0] = 1'b1; mem_rdata[0] = 32'h77;
      tick();
      check("drop.ack", 64'(ack_o[0]), 64'h1);
      check("drop.rdata", 64'(rdata_o[0]), 64'h77);
      for (int i = 0; i < 5; i++) begin
         mem_ready[0] = (i % 2 == 0);
         tick();
         check($sformatf("spur%0d.ack", i), 64'(ack_o[0]), 64'h0);
         check($sformatf("spur%0d.busy", i), 64'(busy_o[0]), 64'h0);
      end
      mem_ready[0] = 1'b0;

      // Short-timeout instance: a good read first so a zeroed rdata is observable.
      req[1] = 2'b10; addr1[1] = 32'h44;
      tick();
      mem_ready[1] = 1'b1; mem_rdata[1] = 32'h1234_5678;
      tick();
      check("to.pre.ack", 64'(ack_o[1]), 64'h2);
      check("to.pre.rdata", 64'(rdata_o[1]), 64'h1234_5678);
      mem_ready[1] = 1'b0; req[1] = 2'b00;
      tick();

      req[1] = 2'b01; addr0[1] = 32'h80;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("to.c%0d.ack", i), 64'(ack_o[1]), 64'h0);
         check($sformatf("to.c%0d.busy", i), 64'(busy_o[1]), 64'h1);
      end
      tick();
      check("to.ack", 64'(ack_o[1]), 64'h1);
      check("to.err", 64'(err_o[1]), 64'h1);
      check("to.rdata", 64'(rdata_o[1]), 64'h0);
      req[1] = 2'b00;
      tick();
      check("to.idle", 64'(busy_o[1]), 64'h0);

      req[1] = 2'b01;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("late.c%0d.ack", i), 64'(ack_o[1]), 64'h0);
         if (i == 4) begin
            mem_ready[1] = 1'b1; mem_rdata[1] = 32'hCAFE_F00D;
         end
      end
      tick();
      check("late.ack", 64'(ack_o[1]), 64'h1);
      check("late.err", 64'(err_o[1]), 64'h0);
      check("late.rdata", 64'(rdata_o[1]), 64'hCAFE_F00D);
      mem_ready[1] = 1'b0; req[1] = 2'b00;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multicycle MIPS datapath. Requester 0 is the core control unit (instruction fetch and lw/sw accesses, address already muxed via IorD). Requester 1 is the program loader/debug port. The block grants the port round-robin, runs one memory transaction at a time against a variable-latency memory, and returns read data or a timeout error to the owner with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max ACCESS cycles before error response; 0 disables timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req[1:0]  in  2  request per requester (0 = core, 1 = loader)
- we[1:0]  in  2  write enable per requester
- addr0, addr1  in  AW each  request address
- wdata0, wdata1  in  DW each  write data
- ack[1:0]  out  2  one-cycle completion pulse to owner
- err  out  1  valid with ack; 1 = timed out
- rdata  out  DW  read data, valid with ack
- busy  out  1  transaction in flight (core stall hint)
- owner  out  1  current/last granted requester
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DW  memory read data, valid with mem_ready

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample req. None set: stay. One set: grant it. Both set: grant the requester not equal to last_grant. On grant, latch we/addr/wdata of the winner into mem_* registers, set owner, set last_grant, set mem_req=1, clear timeout counter, go to ACCESS.
- ACCESS: mem_req held 1, mem_* held stable. mem_ready=1: capture mem_rdata into rdata, set err=0, set ack[owner]=1, drop mem_req, go to RESP. Otherwise increment the counter. If TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready=0: set err=1, set rdata=0, set ack[owner]=1, drop mem_req, go to RESP.
- RESP: ack/err/rdata are valid for exactly this cycle. Clear ack at the following edge and go to IDLE. req is not sampled in RESP.
- Requester protocol: hold req, we, addr, and wdata stable from assertion until ack is seen. req in the cycle after ack is treated as a new request. Changing or dropping req while owned is ignored; the transaction completes and ack is still issued.
- On writes, rdata is still updated from mem_rdata (don't-care value); requesters ignore it.
- mem_ready in IDLE or RESP is ignored.
- busy = (state != IDLE).
- Reset (any state, including mid-ACCESS): state=IDLE. ack=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, owner=0, counter=0. last_grant=1, so the core wins the first contention. An in-flight transaction is abandoned with no ack.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- req sampled high in IDLE at cycle N: mem_req high in cycle N+1.
- mem_ready high in cycle M (ACCESS): ack/rdata valid in cycle M+1; IDLE in M+2.
- Minimum req-to-ack latency is 2 cycles (mem_ready in the first ACCESS cycle). Back-to-back transactions from one requester are spaced 3 cycles apart minimum.
- Timeout: ack with err=1 in cycle N+1+TIMEOUT if mem_ready never arrives.
- mem_ready in the final ACCESS cycle wins over timeout: err=0 with real data.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1…

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), requester IDs REQ_CORE=0 and REQ_LOAD=1, default TIMEOUT constant.
- Sub-module rr_pick2: combinational 2-way round-robin pick (inputs req[1:0], last; outputs valid, winner). Instantiated once. All state stays in mem_arbiter.

## Test plan
- Reset, then req=2'b01, we=0, addr0=0x40, memory replies next cycle with 0x8C020004 -> mem_req in cycle 1 with mem_addr=0x40; ack=2'b01, rdata=0x8C020004, err=0 in cycle 2.
- Both requesters hold req from reset for 4 transactions -> grant order core, loader, core, loader; mem_addr alternates addr0/addr1.
- Loader write, we[1]=1, addr1=0x100, wdata1=0xDEADBEEF, mem_ready after 5 cycles -> mem_we=1 and mem_wdata=0xDEADBEEF held stable all 5 cycles; ack=2'b10 one cycle later.
- TIMEOUT=4, mem_ready never asserted -> ack[owner]=1, err=1, rdata=0 exactly 5 cycles after req sampled. Repeat with mem_ready on the 4th ACCESS cycle -> err=0.
- Assert reset in the 2nd ACCESS cycle -> next cycle mem_req=0, busy=0, no ack. Then a simultaneous request goes to the core.
- Core drops req mid-ACCESS, and spurious mem_ready pulses occur in IDLE -> transaction still acks the core; spurious pulses produce no ack.
